spi_reg_ctrl: RTL
=================

SPI_REG_CTRL -- requirements
Module: spi_reg_ctrl

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning the flip-flop depth of each input synchroniser (legal values 2-3).
REQ-002 SHALL have parameter MAX_ADDR, default 4, meaning the highest valid register address.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port sclk, input, 1 bit: SPI clock, asynchronous to clk.
REQ-006 SHALL have port copi, input, 1 bit: SPI data in.
REQ-007 SHALL have port ncs, input, 1 bit: SPI chip select, active-low.
REQ-008 SHALL have port cipo, output, 1 bit: SPI data out.
REQ-009 SHALL have port en_reg_out_7_0, output, 8 bits: register at address 0x00.
REQ-010 SHALL have port en_reg_out_15_8, output, 8 bits: register at address 0x01.
REQ-011 SHALL have port en_reg_pwm_7_0, output, 8 bits: register at address 0x02.
REQ-012 SHALL have port en_reg_pwm_15_8, output, 8 bits: register at address 0x03.
REQ-013 SHALL have port pwm_duty_cycle, output, 8 bits: register at address 0x04.

Function
REQ-014 SHALL pass sclk, copi and ncs each through a SYNC_STAGES-deep synchroniser before any use.
REQ-015 SHALL detect sclk rising and falling edges on the synchronised signal using one extra history flop.
REQ-016 SHALL use a 16-bit frame, MSB first: bit 15 is R/W (1 = write), bits 14:8 are the address, bits 7:0 are the data.
REQ-017 SHALL implement FSM states IDLE, SHIFT and COMMIT.
REQ-018 IDLE SHALL go to SHIFT when synchronised ncs is low and has been seen high since reset; entry to SHIFT clears the bit counter and the shift register.
REQ-019 SHIFT SHALL shift copi into the register on each sclk rising edge; the bit counter saturates at 17.
REQ-020 SHIFT SHALL leave on synchronised ncs high: to COMMIT if count == 16, R/W = 1 and address <= MAX_ADDR; otherwise to IDLE, discarding the frame.
REQ-021 COMMIT SHALL write the data byte to the addressed register in one cycle and return to IDLE.
REQ-022 The output SHALL update on the clk edge SYNC_STAGES+2 after ncs high is first sampled.
REQ-023 An sclk edge and ncs rising in the same clk cycle SHALL resolve with ncs winning; that sclk edge is ignored.
REQ-024 Short frames (<16 bits), long frames (>16 bits), reads and out-of-range addresses SHALL leave all registers unchanged.
REQ-025 Registers SHALL hold their value indefinitely between writes; back-to-back frames SHALL each commit independently.

Reset
REQ-026 While rst_n = 0 at a clk edge, all five registers, cipo, the counter and the shift register SHALL become 0, and the FSM SHALL go to IDLE.
REQ-027 Reset asserted mid-frame SHALL discard the frame; after reset, no frame is accepted until ncs has been sampled high.

Configuration
REQ-028 SHALL support macro SPI_READBACK_EN.
REQ-029 With SPI_READBACK_EN defined, a read frame (R/W = 0) SHALL drive the addressed register on cipo, MSB first.
REQ-030 Under SPI_READBACK_EN, the MSB SHALL be driven after the 8th sclk rising edge, and each later bit SHALL be driven on each following synchronised sclk falling edge.
REQ-031 Under SPI_READBACK_EN, an invalid address SHALL return 0x00, and cipo SHALL be 0 outside the data phase.
REQ-032 Without SPI_READBACK_EN, cipo SHALL be constant 0, read frames SHALL be discarded, and no readback logic SHALL be synthesised.

Structure
REQ-033 Package spi_reg_pkg SHALL hold FRAME_BITS = 16, the address constants 0x00-0x04, and the FSM state enum.
REQ-034 A sub-module sync_edge (synchroniser plus rise/fall detect, parameter SYNC_STAGES) SHALL be instantiated once each for sclk, copi and ncs.

Verification
REQ-035 Bench: write frame 0x80F0 (addr 0x00, data 0xF0) -> en_reg_out_7_0 = 0xF0 after the ncs rise; all other registers stay 0x00.
REQ-036 Bench: write frame 0x8480 -> pwm_duty_cycle = 0x80; then write 0x8400 -> 0x00; both commit back-to-back.
REQ-037 Bench: write to address 0x30 with data 0xAA -> no register changes; a 15-bit frame and a 17-bit frame -> no register changes.
REQ-038 Bench: rst_n low after 8 bits of frame 0x82FF, then release with ncs still low and clock out the remaining bits -> en_reg_pwm_7_0 = 0x00; the next full frame commits.
REQ-039 Bench: with SPI_READBACK_EN, write 0x8155 then read 0x0100 -> cipo bits 0,1,0,1,0,1,0,1; without the macro -> cipo stays 0 throughout.
REQ-040 Bench: sclk toggled at 1/8 of clk with ncs rising coincident with the 16th edge -> frame discarded per REQ-023.

Source files
------------

// File: rtl/spi_reg_pkg.sv
// Shared constants and FSM state type for the SPI register controller.
package spi_reg_pkg;

  localparam int FRAME_BITS = 16;

  localparam logic [6:0] ADDR_OUT_LO  = 7'h00;
  localparam logic [6:0] ADDR_OUT_HI  = 7'h01;
  localparam logic [6:0] ADDR_PWM_LO  = 7'h02;
  localparam logic [6:0] ADDR_PWM_HI  = 7'h03;
  localparam logic [6:0] ADDR_PWM_DTY = 7'h04;

  localparam logic [4:0] CNT_SAT = 5'd17;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

endpackage

// File: rtl/spi_reg_ctrl_sync_edge.sv
// Multi-flop synchroniser for one asynchronous input, with a history flop
// providing single-cycle rise/fall strobes on the synchronised level.
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   hist_r;

  // synchroniser chain plus edge history
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_r <= {SYNC_STAGES{1'b0}};
      hist_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], din};
      hist_r <= sync_r[SYNC_STAGES-1];
    end
  end

  assign level = sync_r[SYNC_STAGES-1];
  assign rise  = level & ~hist_r;
  assign fall  = ~level & hist_r;

endmodule

// File: rtl/spi_reg_ctrl.sv
// SPI slave writing five 8-bit control registers from 16-bit frames.
// Optional readback on cipo is enabled by defining SPI_READBACK_EN.
module spi_reg_ctrl
  import spi_reg_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_ADDR    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic       cipo,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle
);

  localparam logic [6:0] MAX_ADDR_L = 7'(MAX_ADDR);

  logic sclk_lvl_s, sclk_rise_s, sclk_fall_s;
  logic copi_lvl_s, copi_rise_s, copi_fall_s;
  logic ncs_lvl_s, ncs_rise_s, ncs_fall_s;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .din(sclk),
    .level(sclk_lvl_s), .rise(sclk_rise_s), .fall(sclk_fall_s)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_copi (
    .clk(clk), .rst_n(rst_n), .din(copi),
    .level(copi_lvl_s), .rise(copi_rise_s), .fall(copi_fall_s)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ncs (
    .clk(clk), .rst_n(rst_n), .din(ncs),
    .level(ncs_lvl_s), .rise(ncs_rise_s), .fall(ncs_fall_s)
  );

  state_t                  state_r, state_nxt_s;
  logic [4:0]              cnt_r;
  logic [FRAME_BITS-1:0]   shreg_r;
  logic                    ncs_seen_r;
  logic                    frame_ok_s;

  assign frame_ok_s = (cnt_r == 5'(FRAME_BITS)) && shreg_r[15] &&
                      (shreg_r[14:8] <= MAX_ADDR_L);

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // next-state logic; a deasserted chip select always wins over an sclk edge
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (ncs_seen_r && !ncs_lvl_s) begin
          state_nxt_s = SHIFT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SHIFT: begin
        if (ncs_lvl_s) begin
          if (frame_ok_s) begin
            state_nxt_s = COMMIT;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          state_nxt_s = SHIFT;
        end
      end
      COMMIT:  state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // frame capture and register file
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r           <= 5'd0;
      shreg_r         <= 16'h0000;
      ncs_seen_r      <= 1'b0;
      en_reg_out_7_0  <= 8'h00;
      en_reg_out_15_8 <= 8'h00;
      en_reg_pwm_7_0  <= 8'h00;
      en_reg_pwm_15_8 <= 8'h00;
      pwm_duty_cycle  <= 8'h00;
    end else begin
      if (ncs_lvl_s) begin
        ncs_seen_r <= 1'b1;
      end
      case (state_r)
        IDLE: begin
          if (state_nxt_s == SHIFT) begin
            cnt_r   <= 5'd0;
            shreg_r <= 16'h0000;
          end
        end
        SHIFT: begin
          if (!ncs_lvl_s && sclk_rise_s) begin
            shreg_r <= {shreg_r[14:0], copi_lvl_s};
            if (cnt_r != CNT_SAT) begin
              cnt_r <= cnt_r + 5'd1;
            end
          end
        end
        COMMIT: begin
          case (shreg_r[14:8])
            ADDR_OUT_LO:  en_reg_out_7_0  <= shreg_r[7:0];
            ADDR_OUT_HI:  en_reg_out_15_8 <= shreg_r[7:0];
            ADDR_PWM_LO:  en_reg_pwm_7_0  <= shreg_r[7:0];
            ADDR_PWM_HI:  en_reg_pwm_15_8 <= shreg_r[7:0];
            ADDR_PWM_DTY: pwm_duty_cycle  <= shreg_r[7:0];
            default: begin
            end
          endcase
        end
        default: begin
        end
      endcase
    end
  end

`ifdef SPI_READBACK_EN
  logic [7:0] shift_nxt_s;
  logic [7:0] rd_data_s;
  logic [7:0] tx_r;
  logic       cipo_r;
  logic       unused_s;

  // R/W bit and address as they stand once the 8th bit is shifted in
  assign shift_nxt_s = {shreg_r[6:0], copi_lvl_s};

  // readback source mux; unknown addresses read as zero
  always_comb begin
    rd_data_s = 8'h00;
    if (shift_nxt_s[6:0] <= MAX_ADDR_L) begin
      case (shift_nxt_s[6:0])
        ADDR_OUT_LO:  rd_data_s = en_reg_out_7_0;
        ADDR_OUT_HI:  rd_data_s = en_reg_out_15_8;
        ADDR_PWM_LO:  rd_data_s = en_reg_pwm_7_0;
        ADDR_PWM_HI:  rd_data_s = en_reg_pwm_15_8;
        ADDR_PWM_DTY: rd_data_s = pwm_duty_cycle;
        default:      rd_data_s = 8'h00;
      endcase
    end else begin
      rd_data_s = 8'h00;
    end
  end

  // MSB launched on the 8th rising edge, later bits on falls after edges 9+
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_r   <= 8'h00;
      cipo_r <= 1'b0;
    end else if ((state_r != SHIFT) || ncs_lvl_s) begin
      tx_r   <= 8'h00;
      cipo_r <= 1'b0;
    end else if (sclk_rise_s && (cnt_r == 5'd7) && !shift_nxt_s[7]) begin
      cipo_r <= rd_data_s[7];
      tx_r   <= {rd_data_s[6:0], 1'b0};
    end else if (sclk_fall_s && (cnt_r >= 5'd9)) begin
      cipo_r <= tx_r[7];
      tx_r   <= {tx_r[6:0], 1'b0};
    end
  end

  assign cipo     = cipo_r;
  assign unused_s = ^{copi_rise_s, copi_fall_s, ncs_rise_s, ncs_fall_s, sclk_lvl_s};
`else
  logic unused_s;

  assign cipo     = 1'b0;
  assign unused_s = ^{copi_rise_s, copi_fall_s, ncs_rise_s, ncs_fall_s, sclk_lvl_s,
                      sclk_fall_s};
`endif

endmodule
